// File: rtl/udma_uart_pkg.sv
// Shared types and constants for the uDMA UART transmitter: FSM states,
// parity modes and the data-width encoding of cfg_bits_i.
package udma_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StBreak
    } tx_state_e;

    localparam logic [1:0] PAR_EVEN  = 2'd0;
    localparam logic [1:0] PAR_ODD   = 2'd1;
    localparam logic [1:0] PAR_MARK  = 2'd2;
    localparam logic [1:0] PAR_SPACE = 2'd3;

    localparam logic [2:0] BITS_5 = 3'd0;
    localparam logic [2:0] BITS_6 = 3'd1;
    localparam logic [2:0] BITS_7 = 3'd2;
    localparam logic [2:0] BITS_8 = 3'd3;
    localparam logic [2:0] BITS_9 = 3'd4;

    // Index of the last data bit; encodings above BITS_9 saturate to 9 bits.
    function automatic logic [3:0] last_bit_idx(input logic [2:0] bits);
        if (bits > BITS_9) begin
            return 4'd8;
        end
        return {1'b0, bits} + 4'd4;
    endfunction

    // xor_acc is the XOR of all data bits that were sent.
    function automatic logic parity_bit(input logic [1:0] mode, input logic xor_acc);
        logic p;
        p = 1'b0;
        case (mode)
            PAR_EVEN:  p = xor_acc;
            PAR_ODD:   p = ~xor_acc;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/udma_uart_tx_fifo.sv
// Small synchronous FIFO for the UART TX path; power-of-two depth,
// head word always visible on rdata.
module udma_uart_tx_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/udma_uart_tx_gen.sv
// uDMA UART transmitter: FIFO-buffered, 5..9 data bits, parity, 1/2 stop
// bits, CTS gating and break generation on a registered serial line.
module udma_uart_tx_gen
    import udma_uart_pkg::*;
#(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          cfg_en_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [2:0]                    cfg_bits_i,
    input  logic                          cfg_parity_en_i,
    input  logic [1:0]                    cfg_parity_mode_i,
    input  logic                          cfg_stop_bits_i,
    input  logic                          cfg_cts_en_i,
    input  logic                          cfg_break_i,
    input  logic                          cts_ni,
    input  logic [8:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    logic cts_meta_q, cts_sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_ni;
            cts_sync_q <= cts_meta_q;
        end
    end

    logic       fifo_full, fifo_empty, push, pop;
    logic [8:0] fifo_rdata;

    assign tx_ready_o = cfg_en_i & ~fifo_full;
    assign push       = tx_valid_i & tx_ready_o;

    udma_uart_tx_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .flush  (~cfg_en_i),
        .push   (push),
        .pop    (pop),
        .wdata  (tx_data_i),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level_o)
    );

    tx_state_e        state_q, state_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       last_bit_q, last_bit_d;
    logic             parity_q, parity_d;
    logic             par_en_q, par_en_d;
    logic [1:0]       par_mode_q, par_mode_d;
    logic             stop2_q, stop2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic             tx_q, tx_d;
    logic             gate_open, bit_end, launch;

    assign gate_open = ~cfg_cts_en_i | ~cts_sync_q;
    assign bit_end   = (baud_q == div_q);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        parity_d   = parity_q;
        par_en_d   = par_en_q;
        par_mode_d = par_mode_q;
        stop2_d    = stop2_q;
        div_d      = div_q;
        tx_d       = tx_q;
        baud_d     = bit_end ? '0 : baud_q + 1'b1;
        pop        = 1'b0;
        launch     = 1'b0;

        unique case (state_q)
            StIdle: begin
                launch = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    parity_d = parity_q ^ shift_q[0];
                    if (bit_cnt_q == last_bit_q) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = parity_bit(par_mode_q, parity_q ^ shift_q[0]);
                        end else begin
                            state_d = StStop1;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = {1'b0, shift_q[8:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop1;
                    tx_d    = 1'b1;
                end
            end
            StStop1: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        state_d = StStop2;
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
            StStop2: begin
                if (bit_end) begin
                    launch = 1'b1;
                end
            end
            StBreak: begin
                tx_d = 1'b0;
                if (!cfg_break_i) begin
                    state_d = StStop1;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // Frame boundary: decide the next frame here so back-to-back frames
        // need no idle cycle between the last stop bit and the next start.
        if (launch) begin
            if (cfg_break_i) begin
                state_d = StBreak;
                tx_d    = 1'b0;
                div_d   = cfg_div_i;
                stop2_d = 1'b0;
            end else if (!fifo_empty && gate_open) begin
                pop        = 1'b1;
                state_d    = StStart;
                tx_d       = 1'b0;
                shift_d    = fifo_rdata;
                parity_d   = 1'b0;
                last_bit_d = last_bit_idx(cfg_bits_i);
                par_en_d   = cfg_parity_en_i;
                par_mode_d = cfg_parity_mode_i;
                stop2_d    = cfg_stop_bits_i;
                div_d      = cfg_div_i;
            end else begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        end

        if (state_q == StIdle || state_q == StBreak || state_d != state_q) begin
            baud_d = '0;
        end

        if (!cfg_en_i) begin
            state_d = StIdle;
            tx_d    = 1'b1;
            baud_d  = '0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= 4'd7;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            par_mode_q <= PAR_EVEN;
            stop2_q    <= 1'b0;
            div_q      <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            parity_q   <= parity_d;
            par_en_q   <= par_en_d;
            par_mode_q <= par_mode_d;
            stop2_q    <= stop2_d;
            div_q      <= div_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_udma_uart_tx_gen.sv
// Directed bench for udma_uart_tx_gen: table of single-frame vectors with
// hand-written line patterns, plus sequences for FIFO, break and abort cases.
module tb_udma_uart_tx_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [2:0]  cfg_bits;
    logic        cfg_parity_en;
    logic [1:0]  cfg_parity_mode;
    logic        cfg_stop_bits;
    logic        cfg_cts_en;
    logic        cfg_break;
    logic        cts_n;
    logic [8:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    udma_uart_tx_gen #(
        .DIV_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i             (clk),
        .rstn_i            (rstn),
        .cfg_en_i          (cfg_en),
        .cfg_div_i         (cfg_div),
        .cfg_bits_i        (cfg_bits),
        .cfg_parity_en_i   (cfg_parity_en),
        .cfg_parity_mode_i (cfg_parity_mode),
        .cfg_stop_bits_i   (cfg_stop_bits),
        .cfg_cts_en_i      (cfg_cts_en),
        .cfg_break_i       (cfg_break),
        .cts_ni            (cts_n),
        .tx_data_i         (tx_data),
        .tx_valid_i        (tx_valid),
        .tx_ready_o        (tx_ready),
        .tx_o              (tx),
        .busy_o            (busy),
        .fifo_level_o      (fifo_level)
    );

    // line holds the expected bit sequence in send order, first bit at [len-1].
    typedef struct {
        logic [8:0]  data;
        logic [2:0]  bits;
        logic        par_en;
        logic [1:0]  par_mode;
        logic        stop2;
        logic [15:0] div;
        logic [15:0] line;
        int          len;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input vec_t v);
        cfg_div         = v.div;
        cfg_bits        = v.bits;
        cfg_parity_en   = v.par_en;
        cfg_parity_mode = v.par_mode;
        cfg_stop_bits   = v.stop2;
    endtask

    task automatic push(input logic [8:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Must be entered at a negedge; samples every cycle of every bit.
    task automatic check_frame(input string name, input logic [15:0] line, input int len,
                               input int div, input bit b2b, input bit last);
        int t;
        bit ok;
        t = 0;
        if (b2b) begin
            check({name, "_b2b_start"}, {31'd0, tx}, 32'd0);
        end
        while (tx !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            check({name, "_start_timeout"}, {31'd0, tx}, 32'd0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            ok = 1'b1;
            for (int j = 0; j <= div; j++) begin
                if (tx !== line[len-1-i]) ok = 1'b0;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", name, i), {31'd0, ok}, 32'd1);
        end
        if (last) begin
            check({name, "_idle_tx"}, {31'd0, tx}, 32'd1);
            check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        logic [8:0] words[5];

        vecs[0] = '{9'h0A5, 3'd3, 1'b0, 2'd0, 1'b0, 16'd3, 16'b0101001011,    10};
        vecs[1] = '{9'h1FF, 3'd4, 1'b1, 2'd1, 1'b1, 16'd1, 16'b0111111111011, 13};
        vecs[2] = '{9'h03E, 3'd0, 1'b1, 2'd2, 1'b0, 16'd2, 16'b00111111,      8};
        vecs[3] = '{9'h055, 3'd2, 1'b1, 2'd0, 1'b0, 16'd0, 16'b0101010101,    10};
        vecs[4] = '{9'h02B, 3'd1, 1'b1, 2'd3, 1'b1, 16'd2, 16'b0110101011,    10};
        vecs[5] = '{9'h100, 3'd7, 1'b0, 2'd0, 1'b0, 16'd1, 16'b00000000011,   11};

        rstn = 1'b0; cfg_en = 1'b0; cfg_div = 16'd3; cfg_bits = 3'd3;
        cfg_parity_en = 1'b0; cfg_parity_mode = 2'd0; cfg_stop_bits = 1'b0;
        cfg_cts_en = 1'b0; cfg_break = 1'b0; cts_n = 1'b1;
        tx_data = '0; tx_valid = 1'b0;

        #12;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        cfg_en = 1'b1;
        #1;
        check("en_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);

        // Latency and frame length for 8N1, div 3, 0xA5.
        set_cfg(vecs[0]);
        push(9'h0A5);
        check("lat_pre_tx", {31'd0, tx}, 32'd1);
        check("lat_pre_level", {29'd0, fifo_level}, 32'd1);
        check("lat_pre_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("lat_pop_tx", {31'd0, tx}, 32'd0);
        check("lat_pop_level", {29'd0, fifo_level}, 32'd0);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_len_40", n, 32'd40);
        @(negedge clk);

        foreach (vecs[k]) begin
            set_cfg(vecs[k]);
            push(vecs[k].data);
            check_frame($sformatf("vec%0d", k), vecs[k].line, vecs[k].len,
                        int'(vecs[k].div), 1'b0, 1'b1);
        end

        // FIFO fills while CTS blocks, then drains back-to-back.
        set_cfg(vecs[0]);
        cfg_div = 16'd0;
        cfg_cts_en = 1'b1;
        cts_n = 1'b1;
        repeat (3) @(negedge clk);
        words = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
        for (int i = 0; i < 5; i++) begin
            tx_data = words[i];
            tx_valid = 1'b1;
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        check("full_level", {29'd0, fifo_level}, 32'd4);
        check("full_ready", {31'd0, tx_ready}, 32'd0);
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
        check("cts_hold_tx_high", {31'd0, ok}, 32'd1);
        cts_n = 1'b0;
        check_frame("b2b0", 16'b0100010001, 10, 0, 1'b0, 1'b0);
        check_frame("b2b1", 16'b0010001001, 10, 0, 1'b1, 1'b0);
        check_frame("b2b2", 16'b0110011001, 10, 0, 1'b1, 1'b0);
        check_frame("b2b3", 16'b0001000101, 10, 0, 1'b1, 1'b1);
        check("drain_level", {29'd0, fifo_level}, 32'd0);
        cfg_cts_en = 1'b0;
        cts_n = 1'b1;

        // Break requested mid-frame: frame completes, then low, then div+1 high.
        cfg_div = 16'd1;
        push(9'h0FF);
        @(posedge clk); #1;
        cfg_break = 1'b1;
        @(negedge clk);
        check_frame("brk_frame", 16'b0111111111, 10, 1, 1'b0, 1'b0);
        ok = 1'b1;
        repeat (6) begin
            if (tx !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        check("brk_low", {31'd0, ok}, 32'd1);
        cfg_break = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && tx === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("brk_recovery_len", n, 32'd2);
        check("brk_after_tx", {31'd0, tx}, 32'd1);

        // Enable dropped mid-frame.
        cfg_div = 16'd3;
        tx_data = 9'h000;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_pre_tx", {31'd0, tx}, 32'd0);
        check("abort_pre_level", {29'd0, fifo_level}, 32'd1);
        cfg_en = 1'b0;
        @(posedge clk); #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_level", {29'd0, fifo_level}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, tx_ready}, 32'd0);
        cfg_en = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        check("abort_stays_idle", {31'd0, ok}, 32'd1);

        // Asynchronous reset mid-frame.
        push(9'h000);
        repeat (6) @(posedge clk);
        #3;
        check("arst_pre_tx", {31'd0, tx}, 32'd0);
        rstn = 1'b0;
        #1;
        check("arst_tx", {31'd0, tx}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_level", {29'd0, fifo_level}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_idle_tx", {31'd0, tx}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udma_uart_tx_gen.md
# udma_uart_tx_gen

Parametrised next-generation uDMA UART transmitter. It accepts words from the uDMA TX channel into a small internal FIFO and serialises them LSB-first onto `tx_o`. Frames carry 5–9 data bits, selectable parity mode, 1 or 2 stop bits, optional CTS flow control and break generation. It sits between the uDMA TX stream and the UART pad, replacing the fixed 8-bit transmitter.

## Interface
- `DIV_W`, 16: width of the baud divider.
- `FIFO_DEPTH`, 4: TX FIFO entries; a power of two, ≥2.
- `clk_i`  in  1  system clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `cfg_en_i`  in  1  block enable; low = abort and flush.
- `cfg_div_i`  in  DIV_W  bit period minus one, in clk cycles.
- `cfg_bits_i`  in  3  data bits − 5 (0..4 → 5..9); values 5..7 behave as 4.
- `cfg_parity_en_i`  in  1  insert parity bit.
- `cfg_parity_mode_i`  in  2  0 even, 1 odd, 2 mark (1), 3 space (0).
- `cfg_stop_bits_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `cfg_cts_en_i`  in  1  gate frame start on `cts_ni`.
- `cfg_break_i`  in  1  request break (line held low).
- `cts_ni`  in  1  clear-to-send, active-low, asynchronous; 2-flop synchronised.
- `tx_data_i`  in  9  data word; bits above the configured width are ignored.
- `tx_valid_i`  in  1  data valid.
- `tx_ready_o`  out  1  FIFO can accept.
- `tx_o`  out  1  serial line, registered.
- `busy_o`  out  1  FSM not IDLE or FIFO not empty.
- `fifo_level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- **Push handshake**
  - `tx_ready_o = cfg_en_i & !full`.
  - A word is pushed on any rising edge where `tx_valid_i & tx_ready_o`.
  - Push and pop on the same edge leave the level unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- **IDLE**
  - If `cfg_break_i`, go to BREAK.
  - Otherwise, if the FIFO is not empty and the CTS gate is open (`!cfg_cts_en_i` or synchronised `cts_ni == 0`), pop the head into the shift register, latch the frame config, and go to START.
  - Frame config latched at pop: bits, parity enable/mode, stop bits, divider.
- **Mid-frame config:** changes to `cfg_*` (except `cfg_en_i`) take effect only at the next frame start.
- **Line levels per state**
  - START: `tx_o = 0`.
  - DATA: `tx_o = shift[0]`, shifting right per bit. Bit counter runs from 0 to latched bits − 1; the last bit goes to PARITY if enabled, else STOP1.
  - PARITY: even = XOR of the sent data bits, odd = inverse of that, mark = 1, space = 0.
  - STOP1 and STOP2: `tx_o = 1`. STOP1 goes to STOP2 if two stop bits are latched, else IDLE.
- **BREAK**
  - `tx_o = 0` while `cfg_break_i` is high.
  - When `cfg_break_i` falls, run one STOP1 bit period (`tx_o = 1`), then go to IDLE.
  - A break request during a frame waits until that frame completes.
- **CTS:** deasserting CTS mid-frame does not stop the frame; it only blocks the next pop.
- **`cfg_en_i` low:** on the next edge, FSM → IDLE, FIFO flushed (level 0), `tx_o` = 1, and the baud counter is cleared.

## Timing
- **Reset values:** `tx_o` = 1, `tx_ready_o` = 0 (once enabled, it rises combinationally), `busy_o` = 0, `fifo_level_o` = 0, FSM IDLE.
- **Bit period:** every bit, including START and BREAK-recovery STOP1, lasts exactly `div + 1` cycles.
  - The baud counter reloads to 0 on every state entry.
  - A bit ends when the counter equals the latched `div`.
  - `div = 0` gives one cycle per bit.
- **Latency**
  - Push at edge k with an empty FIFO in IDLE and the gate open: pop at edge k+1, and `tx_o` is low from edge k+1.
  - `tx_o` returns to 1 at the start of STOP1 and stays 1 in IDLE.
- **Frame length:** 1 + bits + parity + stop periods. Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- **Reset mid-frame:** everything returns to reset values immediately (asynchronous).

## Structure
- Package `udma_uart_pkg` holds:
  - the FSM state enum;
  - parity mode constants (`PAR_EVEN`, `PAR_ODD`, `PAR_MARK`, `PAR_SPACE`);
  - the `cfg_bits_i` encoding constants.
- Sub-module `udma_uart_tx_fifo`: synchronous FIFO, width 9, depth `FIFO_DEPTH`, providing full, empty and level.
- The top level holds the CTS synchroniser, the FSM, the shift register, the parity accumulator and the baud counter.

## Test plan
- **8N1**, div = 3, push 0xA5: after the start bit, `tx_o` is 1,0,1,0,0,1,0,1, then stop. Each bit lasts 4 cycles; frame = 40 cycles; `busy_o` drops after it.
- **9-bit odd parity, two stop bits**, push 0x1FF: 9 ones, parity 0, then two high stop bits.
- **5-bit mark parity**, push 0x3E: bits 0,1,1,1,1, then parity 1; upper bits are ignored.
- **FIFO full**
  - Push 5 words with `FIFO_DEPTH` = 4 while CTS is high and `cfg_cts_en_i` = 1: `tx_ready_o` falls at level 4 and `tx_o` stays 1.
  - Assert CTS low: four frames go out back-to-back.
- **Break during a frame**: the frame completes; `tx_o` is held low for the break duration, followed by exactly `div + 1` cycles high.
- **Mid-frame abort**: `cfg_en_i` low mid-frame gives `tx_o` = 1 and `fifo_level_o` = 0 the next cycle. Asynchronous reset mid-frame gives all outputs at their reset values.
